// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: word/address widths, halt opcode and
// the queue entry layout.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and the
// instruction valid/ready output toward the instruction stage.
interface inst_fetch_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO holding fetched {pc, inst}; slot 0 is the registered
// head, so outputs never pass through combinational logic.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic       valid,
  output logic [1:0] count
);

  entry_t     q0, q1;
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0) q0 <= din;
          else             q1 <= din;
        end
        2'b01: begin
          cnt <= cnt - 2'd1;
          q0  <= q1;
        end
        2'b11: begin
          // Occupancy unchanged; new entry lands behind whatever remains.
          if (cnt == 2'd1) q0 <= din;
          else begin
            q0 <= q1;
            q1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = q0;
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, single-outstanding imem read tracking, redirect
// flush and a 2-entry output queue. Optional halt detection: HALT_DETECT_EN.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc, req_pc;
  logic              inflight;
  logic              halted_q;
  logic              halt_hit;
  logic              pop, push, issue;
  logic [1:0]        count;
  logic [2:0]        occ;
  entry_t            din, head;
  logic              head_vld;

  assign pop  = head_vld && bus.inst_ready;
  assign push = inflight && !bus.redirect_valid;
  assign din  = '{pc: req_pc, inst: bus.imem_rdata};

  // Projected occupancy after this cycle's pop, counting the in-flight read.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = !rst && !bus.redirect_valid && !halted_q && !halt_hit
                 && (occ < 3'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + PC_ONE;
        req_pc <= pc;
      end
    end
  end

`ifdef HALT_DETECT_EN
  assign halt_hit = push && (bus.imem_rdata[INST_W-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     halted_q <= 1'b0;
    else if (bus.redirect_valid) halted_q <= 1'b0;
    else if (halt_hit)           halted_q <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted_q = 1'b0;
`endif

  fetch_queue #(.entry_t(entry_t)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .head  (head),
    .valid (head_vld),
    .count (count)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = head_vld;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, backpressure, redirect, PC wrap,
// mid-stream reset and halt (expectations follow HALT_DETECT_EN).
module tb_inst_fetch;
  import cpu_pkg::*;

`ifdef HALT_DETECT_EN
  localparam logic HE = 1'b1;
`else
  localparam logic HE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic halt_mem;
  int   n_run  = 0;
  int   n_fail = 0;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous imem: returns its address, except 0xF000 at word 3 when armed.
  always @(posedge clk)
    bus.imem_rdata <= (halt_mem && bus.imem_addr == 16'h0003) ? 16'hF000 : bus.imem_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt_mem = 1'b0;
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    nxt(); nxt(); #1;
    chk("rst_req",  32'(bus.imem_req),   0);
    chk("rst_addr", 32'(bus.imem_addr),  0);
    chk("rst_vld",  32'(bus.inst_valid), 0);
    chk("rst_inst", 32'(bus.inst),       0);
    chk("rst_pc",   32'(bus.inst_pc),    0);
    chk("rst_halt", 32'(bus.halted),     0);

    rst = 1'b0; #1;
    chk("c0_req",  32'(bus.imem_req),  1);
    chk("c0_addr", 32'(bus.imem_addr), 0);
    nxt(); #1;
    chk("c1_vld",  32'(bus.inst_valid), 0);
    chk("c1_addr", 32'(bus.imem_addr),  1);
    nxt(); #1;
    chk("c2_vld",  32'(bus.inst_valid), 1);
    chk("c2_pc",   32'(bus.inst_pc),    0);
    chk("c2_inst", 32'(bus.inst),       0);
    chk("c2_addr", 32'(bus.imem_addr),  2);

    // Backpressure cycles 3..7: head pinned at 0x0001, queue fills, no issue
    for (int i = 0; i < 5; i++) begin
      nxt(); bus.inst_ready = 1'b0; #1;
      chk("bp_vld",  32'(bus.inst_valid), 1);
      chk("bp_pc",   32'(bus.inst_pc),    1);
      chk("bp_inst", 32'(bus.inst),       1);
      chk("bp_req",  32'(bus.imem_req),   0);
    end
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.inst_ready = 1'b1; #1;
      chk("rel_vld", 32'(bus.inst_valid), 1);
      chk("rel_pc",  32'(bus.inst_pc),    32'(1 + i));
      chk("rel_inst", 32'(bus.inst),      32'(1 + i));
      if (i == 0) chk("rel_addr", 32'(bus.imem_addr), 3);
    end

    // Redirect with a read in flight
    nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100; #1;
    chk("rd_req",  32'(bus.imem_req), 0);
    chk("rd_head", 32'(bus.inst_pc),  5);
    nxt(); bus.redirect_valid = 1'b0; #1;
    chk("rd1_vld",  32'(bus.inst_valid), 0);
    chk("rd1_req",  32'(bus.imem_req),   1);
    chk("rd1_addr", 32'(bus.imem_addr),  16'h0100);
    nxt(); #1;
    chk("rd2_vld",  32'(bus.inst_valid), 0);
    chk("rd2_addr", 32'(bus.imem_addr),  16'h0101);
    nxt(); #1;
    chk("rd3_vld",  32'(bus.inst_valid), 1);
    chk("rd3_pc",   32'(bus.inst_pc),    16'h0100);
    chk("rd3_inst", 32'(bus.inst),       16'h0100);

    // Back-to-back redirects, last wins; then PC wrap
    nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h1234; #1;
    chk("rd4_pc", 32'(bus.inst_pc), 16'h0101);
    nxt(); bus.redirect_pc = 16'hFFFE; #1;
    chk("bb_req", 32'(bus.imem_req), 0);
    nxt(); bus.redirect_valid = 1'b0; #1;
    chk("bb_addr", 32'(bus.imem_addr),  16'hFFFE);
    chk("bb_vld",  32'(bus.inst_valid), 0);
    nxt(); #1;
    chk("wr_addr1", 32'(bus.imem_addr),  16'hFFFF);
    chk("wr_vld1",  32'(bus.inst_valid), 0);
    nxt(); #1;
    chk("wr_addr2", 32'(bus.imem_addr), 16'h0000);
    chk("wr_pc0",   32'(bus.inst_pc),   16'hFFFE);
    chk("wr_inst0", 32'(bus.inst),      16'hFFFE);
    nxt(); #1;
    chk("wr_pc1", 32'(bus.inst_pc), 16'hFFFF);
    nxt(); #1;
    chk("wr_pc2",  32'(bus.inst_pc),    16'h0000);
    chk("wr_vld2", 32'(bus.inst_valid), 1);

    // Asynchronous reset mid-stream
    nxt(); rst = 1'b1; #1;
    chk("mr_req",  32'(bus.imem_req),   0);
    chk("mr_addr", 32'(bus.imem_addr),  0);
    chk("mr_vld",  32'(bus.inst_valid), 0);
    chk("mr_inst", 32'(bus.inst),       0);
    chk("mr_pc",   32'(bus.inst_pc),    0);
    nxt(); rst = 1'b0; halt_mem = 1'b1; #1;
    chk("pr0_addr", 32'(bus.imem_addr), 0);
    chk("pr0_req",  32'(bus.imem_req),  1);
    nxt(); #1;
    chk("pr1_vld", 32'(bus.inst_valid), 0);
    nxt(); #1;
    chk("pr2_pc",   32'(bus.inst_pc), 0);
    chk("pr2_inst", 32'(bus.inst),    0);
    nxt(); #1;
    chk("pr3_pc", 32'(bus.inst_pc), 1);

    // Halt opcode at word 3
    nxt(); #1;
    chk("h4_pc",  32'(bus.inst_pc),  2);
    chk("h4_req", 32'(bus.imem_req), 32'(!HE));
    nxt(); #1;
    chk("h5_pc",   32'(bus.inst_pc),  3);
    chk("h5_inst", 32'(bus.inst),     16'hF000);
    chk("h5_halt", 32'(bus.halted),   32'(HE));
    chk("h5_req",  32'(bus.imem_req), 32'(!HE));
    nxt(); #1;
    chk("h6_vld",  32'(bus.inst_valid), 32'(!HE));
    chk("h6_halt", 32'(bus.halted),     32'(HE));
    nxt(); halt_mem = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0000; #1;
    chk("h7_halt", 32'(bus.halted),   32'(HE));
    chk("h7_req",  32'(bus.imem_req), 0);
    nxt(); bus.redirect_valid = 1'b0; #1;
    chk("h8_halt", 32'(bus.halted),    0);
    chk("h8_req",  32'(bus.imem_req),  1);
    chk("h8_addr", 32'(bus.imem_addr), 0);
    nxt(); nxt(); #1;
    chk("h10_vld", 32'(bus.inst_valid), 1);
    chk("h10_pc",  32'(bus.inst_pc),    0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
